mips_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation MIPS core.
- Replaces the single-cycle PC register, PC+4 adder and PC mux with a PC generator, a valid/ready instruction-memory interface and an instruction FIFO, so memory latency and decode stalls are decoupled.
- Computes the next PC for sequential, beq/bne, j, jr and jal flows from a redirect request issued by the execute stage.
- Produces the jal link value (PC+8).

---
 rtl/mips_pkg.sv | 9 +
 rtl/mips_fetch_fifo.sv | 37 +++
 rtl/mips_fetch_unit.sv | 101 ++++++++++
 tb/tb_mips_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: PC-op codes and fetch FSM encoding shared by fetch and control
package mips_pkg;
  localparam logic [2:0] PCOP_SEQ = 3'b000;
  localparam logic [2:0] PCOP_BR = 3'b001;
  localparam logic [2:0] PCOP_J = 3'b010;
  localparam logic [2:0] PCOP_JR = 3'b011;
  localparam logic [2:0] PCOP_JAL = 3'b100;
  typedef enum logic {FETCH_IDLE = 1'b0, FETCH_WAIT = 1'b1} fetch_state_e;
endpackage

// File: rtl/mips_fetch_fifo.sv
// mips_fetch_fifo: power-of-two circular FIFO with synchronous flush and occupancy count
module mips_fetch_fifo
  import mips_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clock)
    if (push) mem[wr] <= push_data;
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rd];
  assign valid = count != '0;
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: MIPS fetch front end (PC gen, imem valid/ready, instr FIFO); MIPS_FETCH_PERF_EN adds perf counters
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [2:0]      redirect_op,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] redirect_imm,
  input  logic [25:0]     redirect_index,
  input  logic [XLEN-1:0] redirect_rs,
  output logic            link_valid,
  output logic [XLEN-1:0] link_data,
  output logic            misalign_err
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_stall_cycles,
  output logic [15:0]     perf_drops
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  fetch_state_e state, state_n;
  logic [XLEN-1:0] fetch_pc, req_pc, pc4, target;
  logic [CW-1:0] count;
  logic drop, hs, rsp, push, pop;
  assign pc4 = redirect_pc + XLEN'(4);
  always_comb
    target = redirect_op == PCOP_BR ? pc4 + (redirect_imm << 2) :
             (redirect_op == PCOP_J || redirect_op == PCOP_JAL) ? {pc4[XLEN-1:28], redirect_index, 2'b00} :
             redirect_op == PCOP_JR ? {redirect_rs[XLEN-1:2], 2'b00} : pc4;
  assign hs = imem_req_valid && imem_req_ready;
  assign rsp = state == FETCH_WAIT && imem_rsp_valid;
  assign push = rsp && !drop && !redirect_valid;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  assign imem_req_addr = fetch_pc;
  always_ff @(posedge clock)
    state <= !reset ? FETCH_IDLE : state_n;
  always_comb
    state_n = hs || (state == FETCH_WAIT && !imem_rsp_valid) ? FETCH_WAIT : FETCH_IDLE;
  // a live response needs one slot for itself before a back-to-back request may go out
  always_comb
    imem_req_valid = reset && (state == FETCH_IDLE ? count < DEPTH_C :
                               imem_rsp_valid && (count + CW'(!drop)) < DEPTH_C);
  always_ff @(posedge clock)
    if (hs) req_pc <= fetch_pc;
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc <= RESET_VECTOR;
      drop <= 1'b0;
      link_valid <= 1'b0;
      link_data <= '0;
      misalign_err <= 1'b0;
    end else begin
      fetch_pc <= redirect_valid ? target : hs ? fetch_pc + XLEN'(4) : fetch_pc;
      drop <= redirect_valid ? hs || (state == FETCH_WAIT && !imem_rsp_valid) : rsp ? 1'b0 : drop;
      link_valid <= redirect_valid && redirect_op == PCOP_JAL;
      if (redirect_valid && redirect_op == PCOP_JAL) link_data <= redirect_pc + XLEN'(8);
      misalign_err <= redirect_valid && redirect_op == PCOP_JR && redirect_rs[1:0] != 2'b00;
    end
  end
  mips_fetch_fifo #(.W(2 * XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(redirect_valid),
    .push(push),
    .push_data({req_pc, imem_rsp_data}),
    .pop(pop),
    .head({instr_pc, instr_data}),
    .valid(instr_valid),
    .count(count)
  );
`ifdef MIPS_FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_redirects <= '0;
      perf_stall_cycles <= '0;
      perf_drops <= '0;
    end else begin
      if (redirect_valid && perf_redirects != '1) perf_redirects <= perf_redirects + 32'd1;
      if (!instr_valid && !redirect_valid && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (rsp && (drop || redirect_valid) && perf_drops != '1) perf_drops <= perf_drops + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: randomized scoreboard bench for mips_fetch_unit against a PC-stream reference model
module tb_mips_fetch_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] RV = 32'h0;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic instr_valid, instr_ready = 1'b0;
  logic [31:0] instr_data, instr_pc;
  logic redirect_valid = 1'b0;
  logic [2:0] redirect_op = '0;
  logic [31:0] redirect_pc = '0, redirect_imm = '0, redirect_rs = '0;
  logic [25:0] redirect_index = '0;
  logic link_valid, misalign_err;
  logic [31:0] link_data;

  mips_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_op(redirect_op), .redirect_pc(redirect_pc),
    .redirect_imm(redirect_imm), .redirect_index(redirect_index), .redirect_rs(redirect_rs),
    .link_valid(link_valid), .link_data(link_data), .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0, cyc = 0;
  logic rst_q;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    rst_q <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] model_target(input logic [2:0] op, input logic [31:0] pc,
      input logic [31:0] imm, input logic [25:0] idx, input logic [31:0] rs);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    case (op)
      3'd1: return nxt + imm * 32'd4;
      3'd2, 3'd4: return (nxt & 32'hF000_0000) | ({6'd0, idx} << 2);
      3'd3: return rs & 32'hFFFF_FFFC;
      default: return nxt;
    endcase
  endfunction

  logic [31:0] exp_pc = RV, req_exp = RV;
  logic [31:0] link_q[$];
  int link_cyc_q[$], mis_q[$];
  int lat_min = 1, lat_max = 1, rdy_pct = 100, ir_pct = 100, redir_pct = 0;
  int pend_cnt = 0, hs_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit force_redir = 0;
  logic [2:0] f_op;
  logic [31:0] f_pc, f_imm, f_rs;
  logic [25:0] f_idx;

  task automatic step(input bit rst_n);
    logic [31:0] r;
    @(negedge clock);
    reset = rst_n;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = $urandom;
    if (pend_cnt == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(pend_addr);
    end
    if (pend_cnt > 0) pend_cnt--;
    if (!rst_n) begin
      pend_cnt = 0;
      exp_pc = RV;
      req_exp = RV;
      link_q.delete();
      link_cyc_q.delete();
      mis_q.delete();
    end
    imem_req_ready = $urandom_range(99) < rdy_pct;
    instr_ready = $urandom_range(99) < ir_pct;
    redirect_valid = 1'b0;
    if (rst_n && (force_redir || $urandom_range(99) < redir_pct)) begin
      if (!force_redir) begin
        r = $urandom;
        f_op = 3'($urandom_range(7));
        f_pc = $urandom & 32'hFFFF_FFFC;
        f_imm = {{16{r[15]}}, r[15:0]};
        f_idx = 26'($urandom);
        f_rs = $urandom;
      end
      force_redir = 0;
      redirect_valid = 1'b1;
      redirect_op = f_op;
      redirect_pc = f_pc;
      redirect_imm = f_imm;
      redirect_index = f_idx;
      redirect_rs = f_rs;
      exp_pc = model_target(f_op, f_pc, f_imm, f_idx, f_rs);
      req_exp = exp_pc;
      if (f_op == 3'd4) begin
        link_q.push_back(f_pc + 32'd8);
        link_cyc_q.push_back(cyc + 1);
      end
      if (f_op == 3'd3 && f_rs[1:0] != 2'b00) mis_q.push_back(cyc + 1);
    end else begin
      redirect_op = 3'($urandom);
      redirect_pc = $urandom;
    end
    #1;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      check("one_outstanding", pend_cnt, 0);
      pend_cnt = $urandom_range(lat_max, lat_min);
      pend_addr = imem_req_addr;
      hs_cnt++;
    end
  endtask

  task automatic redirect(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
      input logic [25:0] idx, input logic [31:0] rs);
    f_op = op;
    f_pc = pc;
    f_imm = imm;
    f_idx = idx;
    f_rs = rs;
    force_redir = 1;
    step(1);
  endtask

  always @(negedge clock) begin
    #2;
    if (!reset) check("req_valid_in_reset", imem_req_valid, 0);
    if (!rst_q) begin
      check("instr_valid_reset", instr_valid, 0);
      check("link_valid_reset", link_valid, 0);
      check("misalign_reset", misalign_err, 0);
    end else begin
      if (link_valid) begin
        check("link_expected", link_q.size() != 0, 1);
        if (link_q.size() != 0) begin
          check("link_data", link_data, link_q.pop_front());
          check("link_cycle", cyc, link_cyc_q.pop_front());
        end
      end
      if (misalign_err) begin
        check("misalign_expected", mis_q.size() != 0, 1);
        if (mis_q.size() != 0) check("misalign_cycle", cyc, mis_q.pop_front());
      end
    end
    if (reset && !redirect_valid) begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, req_exp);
        req_exp += 32'd4;
      end
      if (instr_valid && instr_ready) begin
        check("instr_pc", instr_pc, exp_pc);
        check("instr_data", instr_data, mem_word(exp_pc));
        exp_pc += 32'd4;
      end
    end
  end

  initial begin
    // streaming after reset with a 1-cycle always-ready memory
    repeat (3) step(0);
    hs_cnt = 0;
    step(1);
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, RV);
    step(1);
    check("instr_valid_cycle2", instr_valid, 0);
    step(1);
    check("instr_valid_cycle3", instr_valid, 1);
    step(1);
    check("consecutive_hs", hs_cnt, 4);
    repeat (10) step(1);
    // fill the FIFO with decode stalled, then free one slot
    ir_pct = 0;
    repeat (2) step(0);
    hs_cnt = 0;
    repeat (12) step(1);
    check("fill_hs", hs_cnt, 4);
    check("full_req_valid", imem_req_valid, 0);
    check("full_instr_valid", instr_valid, 1);
    ir_pct = 100;
    step(1);
    ir_pct = 0;
    hs_cnt = 0;
    repeat (8) step(1);
    check("refill_hs", hs_cnt, 1);
    // directed redirects with a 3-cycle memory so a request is outstanding
    ir_pct = 100;
    lat_min = 3;
    lat_max = 3;
    repeat (10) step(1);
    redirect(3'b001, 32'h20, 32'hFFFF_FFFE, 26'h0, 32'h0);
    repeat (12) step(1);
    redirect(3'b100, 32'h40, 32'h0, 26'h000100, 32'h0);
    repeat (12) step(1);
    redirect(3'b011, 32'h0, 32'h0, 26'h0, 32'h0000_1003);
    repeat (12) step(1);
    redirect(3'b111, 32'h80, 32'h0, 26'h0, 32'h0);
    repeat (12) step(1);
    // randomized traffic
    lat_min = 1;
    lat_max = 4;
    rdy_pct = 70;
    ir_pct = 60;
    redir_pct = 5;
    repeat (3000) step(1);
    redir_pct = 0;
    rdy_pct = 100;
    ir_pct = 100;
    repeat (30) step(1);
    // reset lands in WAIT with the response arriving in the same cycle
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 10 && pend_cnt != 1; i++) step(1);
    check("wait_reached", pend_cnt, 1);
    step(0);
    step(0);
    hs_cnt = 0;
    step(1);
    check("post_reset_req_valid", imem_req_valid, 1);
    check("post_reset_req_addr", imem_req_addr, RV);
    repeat (10) step(1);
    check("link_q_empty", link_q.size(), 0);
    check("misalign_q_empty", mis_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
